// File: rtl/wb_merge_if.sv
// Register-file write-back bundle: one synchronous write port (enable, address, data).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface write_back_ifc #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = `DATA_WIDTH
);
    logic              uses_rw;
    logic [ADDR_W-1:0] rw_addr;
    logic [DATA_W-1:0] rw_data;

    modport out (output uses_rw, rw_addr, rw_data);
    modport rf  (input  uses_rw, rw_addr, rw_data);
endinterface

// File: rtl/wb_merge.sv
// Write-back merge: loads take the register-file port unconditionally, ALU results queue in a FIFO.
// Optional macro WB_MERGE_BYPASS_EN lets an ALU result skip an empty FIFO straight into the output register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_merge #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = `DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_alu_valid,
    input  logic [ADDR_W-1:0]          i_alu_addr,
    input  logic [DATA_W-1:0]          i_alu_data,
    output logic                       o_alu_ready,
    input  logic                       i_mem_valid,
    input  logic [ADDR_W-1:0]          i_mem_addr,
    input  logic [DATA_W-1:0]          i_mem_data,
    write_back_ifc.out                 o_wb,
    input  logic [ADDR_W-1:0]          i_query_addr,
    output logic                       o_query_hit,
    output logic [DATA_W-1:0]          o_query_data,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              uses_rw_q, uses_rw_d;
    logic [ADDR_W-1:0] rw_addr_q, rw_addr_d;
    logic [DATA_W-1:0] rw_data_q, rw_data_d;

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic alu_ready;
    logic alu_take;
    logic mem_take;
    logic fifo_empty;
    logic bypass;
    logic push;
    logic pop;

    // Ready looks only at registered occupancy, so a full FIFO refuses even while popping.
    assign alu_ready  = (count_q < DEPTH_C);
    assign alu_take   = i_alu_valid && alu_ready && (i_alu_addr != '0);
    assign mem_take   = i_mem_valid && (i_mem_addr != '0);
    assign fifo_empty = (count_q == '0);

`ifdef WB_MERGE_BYPASS_EN
    assign bypass = fifo_empty && !mem_take && alu_take;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = !mem_take && !fifo_empty;
    assign push = alu_take && !bypass;

    always_comb begin
        uses_rw_d = 1'b0;
        rw_addr_d = rw_addr_q;
        rw_data_d = rw_data_q;
        if (mem_take) begin
            uses_rw_d = 1'b1;
            rw_addr_d = i_mem_addr;
            rw_data_d = i_mem_data;
        end else if (!fifo_empty) begin
            uses_rw_d = 1'b1;
            rw_addr_d = fifo_addr_q[rd_ptr_q];
            rw_data_d = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            uses_rw_d = 1'b1;
            rw_addr_d = i_alu_addr;
            rw_data_d = i_alu_data;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            uses_rw_q <= 1'b0;
            rw_addr_q <= '0;
            rw_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            uses_rw_q <= uses_rw_d;
            rw_addr_q <= rw_addr_d;
            rw_data_q <= rw_data_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= i_alu_addr;
            fifo_data_q[wr_ptr_q] <= i_alu_data;
        end
    end

    // Scan oldest to youngest (output register, then head..tail) so the last match is the youngest.
    logic [PTR_W-1:0] scan_idx;
    always_comb begin
        o_query_hit  = 1'b0;
        o_query_data = '0;
        scan_idx     = rd_ptr_q;
        if (i_query_addr != '0) begin
            if (uses_rw_q && (rw_addr_q == i_query_addr)) begin
                o_query_hit  = 1'b1;
                o_query_data = rw_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                scan_idx = rd_ptr_q + PTR_W'(k);
                if ((CNT_W'(k) < count_q) && (fifo_addr_q[scan_idx] == i_query_addr)) begin
                    o_query_hit  = 1'b1;
                    o_query_data = fifo_data_q[scan_idx];
                end
            end
        end
    end

    assign o_alu_ready  = alu_ready;
    assign o_count      = count_q;
    assign o_wb.uses_rw = uses_rw_q;
    assign o_wb.rw_addr = rw_addr_q;
    assign o_wb.rw_data = rw_data_q;
endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: queue-based reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_wb_merge;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [5:0]  i_alu_addr = '0;
    logic [31:0] i_alu_data = '0;
    logic        o_alu_ready;
    logic        i_mem_valid = 1'b0;
    logic [5:0]  i_mem_addr = '0;
    logic [31:0] i_mem_data = '0;
    logic [5:0]  i_query_addr = '0;
    logic        o_query_hit;
    logic [31:0] o_query_data;
    logic [2:0]  o_count;

    write_back_ifc #(.ADDR_W(6), .DATA_W(32)) wb_if ();

    wb_merge #(.DEPTH(DEPTH), .ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_alu_valid(i_alu_valid), .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
        .o_alu_ready(o_alu_ready),
        .i_mem_valid(i_mem_valid), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .o_wb(wb_if),
        .i_query_addr(i_query_addr), .o_query_hit(o_query_hit), .o_query_data(o_query_data),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending ALU writes as a queue, plus the output register.
    typedef struct { logic [5:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    logic        m_uses = 1'b0;
    logic [5:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_uses = 1'b0; m_addr = '0; m_data = '0;
            started = 1'b1;
        end else begin
            bit take, load, byp;
            ent_t e;
            take = i_alu_valid && (mq.size() < DEPTH) && (i_alu_addr != 0);
            load = i_mem_valid && (i_mem_addr != 0);
`ifdef WB_MERGE_BYPASS_EN
            byp = take && !load && (mq.size() == 0);
`else
            byp = 1'b0;
`endif
            if (load) begin
                m_uses = 1'b1; m_addr = i_mem_addr; m_data = i_mem_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_uses = 1'b1; m_addr = e.a; m_data = e.d;
            end else if (byp) begin
                m_uses = 1'b1; m_addr = i_alu_addr; m_data = i_alu_data;
            end else begin
                m_uses = 1'b0;
            end
            if (take && !byp) mq.push_back('{a: i_alu_addr, d: i_alu_data});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic        hit;
            logic [31:0] qd;
            hit = 1'b0; qd = '0;
            if (i_query_addr != 0) begin
                if (m_uses && m_addr == i_query_addr) begin hit = 1'b1; qd = m_data; end
                foreach (mq[k]) if (mq[k].a == i_query_addr) begin hit = 1'b1; qd = mq[k].d; end
            end
            chk("model_ready", {31'd0, o_alu_ready}, {31'd0, mq.size() < DEPTH});
            chk("model_count", {29'd0, o_count}, 32'(mq.size()));
            chk("model_uses_rw", {31'd0, wb_if.uses_rw}, {31'd0, m_uses});
            chk("model_rw_addr", {26'd0, wb_if.rw_addr}, {26'd0, m_addr});
            chk("model_rw_data", wb_if.rw_data, m_data);
            chk("model_query_hit", {31'd0, o_query_hit}, {31'd0, hit});
            chk("model_query_data", o_query_data, qd);
        end
    end

    task automatic drive(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [5:0] ma, input logic [31:0] md,
                         input logic [5:0] qa);
        i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
        i_mem_valid = mv; i_mem_addr = ma; i_mem_data = md;
        i_query_addr = qa;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_uses_rw", {31'd0, wb_if.uses_rw}, 0);
        chk("rst_count", {29'd0, o_count}, 0);
        chk("rst_ready", {31'd0, o_alu_ready}, 1);
        chk("rst_rw_addr", {26'd0, wb_if.rw_addr}, 0);

        // Single ALU write r5 = 0x1234
        drive(1, 5, 32'h1234, 0, 0, 0, 0);
`ifdef WB_MERGE_BYPASS_EN
        chk("single_uses_rw_c1", {31'd0, wb_if.uses_rw}, 1);
        chk("single_addr_c1", {26'd0, wb_if.rw_addr}, 5);
        chk("single_data_c1", wb_if.rw_data, 32'h1234);
        idle(1);
`else
        chk("single_uses_rw_c1", {31'd0, wb_if.uses_rw}, 0);
        chk("single_count_c1", {29'd0, o_count}, 1);
        idle(1);
        chk("single_uses_rw_c2", {31'd0, wb_if.uses_rw}, 1);
        chk("single_addr_c2", {26'd0, wb_if.rw_addr}, 5);
        chk("single_data_c2", wb_if.rw_data, 32'h1234);
`endif
        idle(1);
        chk("single_done", {31'd0, wb_if.uses_rw}, 0);
        chk("hold_addr", {26'd0, wb_if.rw_addr}, 5);

        // Collision: ALU r3 = 0xA with load r7 = 0xB
        drive(1, 3, 32'hA, 1, 7, 32'hB, 0);
        chk("coll_addr_c1", {26'd0, wb_if.rw_addr}, 7);
        chk("coll_data_c1", wb_if.rw_data, 32'hB);
        chk("coll_count_c1", {29'd0, o_count}, 1);
        idle(1);
        chk("coll_addr_c2", {26'd0, wb_if.rw_addr}, 3);
        chk("coll_data_c2", wb_if.rw_data, 32'hA);
        chk("coll_count_c2", {29'd0, o_count}, 0);
        idle(2);

        // Back-pressure: loads for 6 cycles with ALU offered every cycle
        for (int i = 0; i < 6; i++) begin
            drive(1, 6'(20 + i), 32'(200 + i), 1, 6'(10 + i), 32'(100 + i), 0);
            chk("bp_load_addr", {26'd0, wb_if.rw_addr}, 32'(10 + i));
            if (i == 2) chk("bp_ready_3", {31'd0, o_alu_ready}, 1);
            if (i == 3) begin
                chk("bp_count_full", {29'd0, o_count}, 4);
                chk("bp_ready_low", {31'd0, o_alu_ready}, 0);
            end
        end
        for (int j = 0; j < 4; j++) begin
            idle(1);
            chk("bp_drain_addr", {26'd0, wb_if.rw_addr}, 32'(20 + j));
            chk("bp_drain_data", wb_if.rw_data, 32'(200 + j));
        end
        chk("bp_ready_back", {31'd0, o_alu_ready}, 1);
        idle(1);

        // Register zero
        drive(1, 0, 32'hFF, 0, 0, 0, 0);
        chk("r0_count", {29'd0, o_count}, 0);
        chk("r0_uses_rw", {31'd0, wb_if.uses_rw}, 0);
        idle(1);
        chk("r0_uses_rw_c2", {31'd0, wb_if.uses_rw}, 0);
        drive(0, 0, 0, 1, 0, 32'h55, 0);
        chk("load_r0_filtered", {31'd0, wb_if.uses_rw}, 0);

        // Lookup: two pending r9 writes held in the FIFO behind loads
        drive(1, 9, 1, 1, 11, 5, 9);
        drive(1, 9, 2, 1, 12, 6, 9);
        chk("lk_count", {29'd0, o_count}, 2);
        chk("lk_r9_hit", {31'd0, o_query_hit}, 1);
        chk("lk_r9_data", o_query_data, 2);
        i_query_addr = 4; #1;
        chk("lk_r4_hit", {31'd0, o_query_hit}, 0);
        chk("lk_r4_data", o_query_data, 0);
        i_query_addr = 12; #1;
        chk("lk_r12_hit", {31'd0, o_query_hit}, 1);
        chk("lk_r12_data", o_query_data, 6);
        i_query_addr = 0; #1;
        chk("lk_r0_hit", {31'd0, o_query_hit}, 0);
        idle(3);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) drive(1, 6'(30 + i), 32'(i), 1, 6'(40 + i), 32'(i), 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_count", {29'd0, o_count}, 0);
        chk("mid_rst_uses_rw", {31'd0, wb_if.uses_rw}, 0);
        idle(1);

        // Mixed traffic against the model
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 4), 6'($urandom_range(8, 15)), $urandom,
                  6'($urandom_range(0, 15)));
        end
        idle(DEPTH + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
